// File: rtl/sram_bridge_pkg.sv
// Shared types and parameter-legality helpers for the CPU data-SRAM bridge.
package sram_bridge_pkg;

   localparam int LAT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } bridge_state_t;

   function automatic bit rd_lat_legal(input int lat);
      return (lat >= 2) && (lat <= 15);
   endfunction

   function automatic bit wr_lat_legal(input int lat);
      return (lat >= 1) && (lat <= 15);
   endfunction

endpackage

// File: rtl/data_sram_bridge_lat_counter.sv
// Loadable down-counter; done flags the last wait cycle or a zero-length load.
module lat_counter
   import sram_bridge_pkg::*;
(
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             load_i,
   input  logic [LAT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             done_o
);

   logic [LAT_W-1:0] count_q;
   logic [LAT_W-1:0] count_d;

   // Saturates at zero so the count never wraps.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != {LAT_W{1'b0}})) begin
         count_d = count_q - LAT_W'(1);
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= {LAT_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign done_o = load_i ? (load_val_i == {LAT_W{1'b0}}) : (count_q == LAT_W'(1));

endmodule

// File: rtl/data_sram_bridge.sv
// CPU data-SRAM port to 1-cycle synchronous RAM bridge with configurable
// read/write completion latency and a held read-data register.
module data_sram_bridge
   import sram_bridge_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 2,
   parameter int WR_LAT = 1,
   parameter int WR_ACK = 1
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                cpu_en_i,
   input  logic [DATA_W/8-1:0] cpu_wen_i,
   input  logic [ADDR_W-1:0]   cpu_addr_i,
   input  logic [DATA_W-1:0]   cpu_wdata_i,
   output logic [DATA_W-1:0]   cpu_rdata_o,
   output logic                cpu_data_ok_o,
   output logic                ram_en_o,
   output logic [DATA_W/8-1:0] ram_wen_o,
   output logic [ADDR_W-1:0]   ram_addr_o,
   output logic [DATA_W-1:0]   ram_wdata_o,
   input  logic [DATA_W-1:0]   ram_rdata_i
);

   localparam logic [LAT_W-1:0] RD_LOAD = LAT_W'(RD_LAT - 1);
   localparam logic [LAT_W-1:0] WR_LOAD = LAT_W'(WR_LAT - 1);

   if (!rd_lat_legal(RD_LAT)) begin : g_rd_lat_bad
      $error("data_sram_bridge: RD_LAT must be in 2..15");
   end
   if (!wr_lat_legal(WR_LAT)) begin : g_wr_lat_bad
      $error("data_sram_bridge: WR_LAT must be in 1..15");
   end

   bridge_state_t     state_q, state_d;
   logic              data_ok_q, data_ok_d;
   logic              rd_cap_q, rd_cap_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic             is_write_s;
   logic             accept_s;
   logic             load_s;
   logic [LAT_W-1:0] load_val_s;
   logic             cnt_done_s;

   assign is_write_s = |cpu_wen_i;
   assign accept_s   = (state_q == IDLE) && cpu_en_i && !reset_i;
   // Legacy writes finish in the accept cycle and never start a latency count.
   assign load_s     = accept_s && !(is_write_s && (WR_ACK == 0));
   assign load_val_s = is_write_s ? WR_LOAD : RD_LOAD;

   lat_counter u_lat_counter (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .load_i     (load_s),
      .load_val_i (load_val_s),
      .dec_i      (state_q == WAIT),
      .done_o     (cnt_done_s)
   );

   always_comb begin
      state_d   = state_q;
      data_ok_d = 1'b0;
      rd_cap_d  = accept_s && !is_write_s;
      rdata_d   = rd_cap_q ? ram_rdata_i : rdata_q;
      case (state_q)
         IDLE: begin
            if (load_s) begin
               state_d = cnt_done_s ? DONE : WAIT;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (cnt_done_s) begin
               state_d = DONE;
            end else begin
               state_d = WAIT;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      data_ok_d = (state_d == DONE);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         data_ok_q <= 1'b0;
         rd_cap_q  <= 1'b0;
         rdata_q   <= {DATA_W{1'b0}};
      end else begin
         state_q   <= state_d;
         data_ok_q <= data_ok_d;
         rd_cap_q  <= rd_cap_d;
         rdata_q   <= rdata_d;
      end
   end

   assign ram_en_o      = accept_s;
   assign ram_wen_o     = accept_s ? cpu_wen_i : {(DATA_W/8){1'b0}};
   assign ram_addr_o    = cpu_addr_i;
   assign ram_wdata_o   = cpu_wdata_i;
   assign cpu_rdata_o   = rdata_q;
   assign cpu_data_ok_o = data_ok_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Three bridge configurations against a cycle-count transaction model,
// plus literal latency/data expectations for directed transactions.
module tb_data_sram_bridge;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   chk = 0;
   int   err = 0;

   logic        en_s       [3];
   logic [3:0]  wen_s      [3];
   logic [31:0] addr_s     [3];
   logic [31:0] wdata_s    [3];
   logic [31:0] rdata_s    [3];
   logic        ok_s       [3];
   logic        ram_en_s   [3];
   logic [3:0]  ram_wen_s  [3];
   logic [31:0] ram_addr_s [3];
   logic [31:0] ram_wdata_s[3];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int rdl(input int g);
      return (g == 0) ? 2 : ((g == 1) ? 5 : 6);
   endfunction
   function automatic int wrl(input int g);
      return (g == 1) ? 2 : 1;
   endfunction
   function automatic bit ack(input int g);
      return g != 2;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [31:0] mem [256];
      logic [31:0] ram_q;

      data_sram_bridge #(
         .RD_LAT ((g == 0) ? 2 : ((g == 1) ? 5 : 6)),
         .WR_LAT ((g == 1) ? 2 : 1),
         .WR_ACK ((g == 2) ? 0 : 1)
      ) u_dut (
         .clk_i         (clk),
         .reset_i       (rst),
         .cpu_en_i      (en_s[g]),
         .cpu_wen_i     (wen_s[g]),
         .cpu_addr_i    (addr_s[g]),
         .cpu_wdata_i   (wdata_s[g]),
         .cpu_rdata_o   (rdata_s[g]),
         .cpu_data_ok_o (ok_s[g]),
         .ram_en_o      (ram_en_s[g]),
         .ram_wen_o     (ram_wen_s[g]),
         .ram_addr_o    (ram_addr_s[g]),
         .ram_wdata_o   (ram_wdata_s[g]),
         .ram_rdata_i   (ram_q)
      );

      always @(posedge clk) begin
         if (ram_en_s[g]) begin
            for (int b = 0; b < 4; b++)
               if (ram_wen_s[g][b]) mem[ram_addr_s[g][9:2]][8*b +: 8] <= ram_wdata_s[g][8*b +: 8];
            ram_q <= mem[ram_addr_s[g][9:2]];
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chk++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // Transaction model: acceptance and completion are computed from cycle numbers.
   logic [31:0] mem_m [3][256];
   logic [31:0] rd_m [3];
   logic [31:0] pend_m [3];
   int          okc_m [3] = '{-1, -1, -1};
   int          rdv_m [3] = '{-1, -1, -1};
   int          free_m[3] = '{0, 0, 0};
   bit          kn_m  [3] = '{0, 0, 0};
   logic        x_en;
   int          idx;

   always @(negedge clk) begin
      for (int g = 0; g < 3; g++) begin
         x_en = !rst && en_s[g] && (cyc >= free_m[g]);
         if (cyc == rdv_m[g]) rd_m[g] = pend_m[g];
         check($sformatf("ram_en[%0d]", g), 32'(ram_en_s[g]), 32'(x_en));
         check($sformatf("ram_wen[%0d]", g), 32'(ram_wen_s[g]), x_en ? 32'(wen_s[g]) : 32'd0);
         if (x_en) begin
            check($sformatf("ram_addr[%0d]", g), ram_addr_s[g], addr_s[g]);
            check($sformatf("ram_wdata[%0d]", g), ram_wdata_s[g], wdata_s[g]);
         end
         if (kn_m[g]) begin
            check($sformatf("data_ok[%0d]", g), 32'(ok_s[g]), 32'(cyc == okc_m[g]));
            check($sformatf("rdata[%0d]", g), rdata_s[g], rd_m[g]);
         end
         idx = int'(addr_s[g][9:2]);
         if (rst) begin
            okc_m[g]  = -1;
            rdv_m[g]  = -1;
            free_m[g] = cyc + 1;
            rd_m[g]   = 32'h0;
            kn_m[g]   = 1'b1;
         end else if (x_en && (wen_s[g] == 4'h0)) begin
            pend_m[g] = mem_m[g][idx];
            rdv_m[g]  = cyc + 2;
            okc_m[g]  = cyc + rdl(g);
            free_m[g] = cyc + rdl(g) + 1;
         end else if (x_en) begin
            for (int b = 0; b < 4; b++)
               if (wen_s[g][b]) mem_m[g][idx][8*b +: 8] = wdata_s[g][8*b +: 8];
            okc_m[g]  = ack(g) ? cyc + wrl(g) : -1;
            free_m[g] = ack(g) ? cyc + wrl(g) + 1 : cyc + 1;
         end
      end
   end

   // Called at posedge+1; holds the request until data_ok, then drops it.
   task automatic req(input int g, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                      input int exp_lat, input bit chk_rd, input logic [31:0] exp_rd);
      int lat;
      bit got;
      got = 1'b0;
      lat = 99;
      en_s[g] = 1'b1; wen_s[g] = w; addr_s[g] = a; wdata_s[g] = d;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (ok_s[g]) begin
            got = 1'b1;
            lat = k;
            break;
         end
      end
      check($sformatf("latency[%0d]%s", g, got ? "" : " timeout"), 32'(lat), 32'(exp_lat));
      if (chk_rd) check($sformatf("read_value[%0d]", g), rdata_s[g], exp_rd);
      @(posedge clk); #1;
      en_s[g] = 1'b0; wen_s[g] = 4'h0;
   endtask

   int n_en;
   int n_ok;

   initial begin
      rst = 1'b1;
      for (int g = 0; g < 3; g++) begin
         en_s[g] = 1'b1; wen_s[g] = 4'h0; addr_s[g] = 32'h0; wdata_s[g] = 32'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int g = 0; g < 3; g++) en_s[g] = 1'b0;
      @(posedge clk); #1;

      // RD_LAT=2 instance: default latency, back-to-back reads, byte enables
      req(0, 4'hF, 32'h40, 32'h1234_5678, 1, 1'b0, 32'h0);
      req(0, 4'h0, 32'h40, 32'h0, 2, 1'b1, 32'h1234_5678);
      req(0, 4'h0, 32'h40, 32'h0, 2, 1'b1, 32'h1234_5678);
      req(0, 4'hF, 32'h44, 32'h1111_1111, 1, 1'b0, 32'h0);
      req(0, 4'b0010, 32'h44, 32'hAABB_CCDD, 1, 1'b0, 32'h0);
      req(0, 4'h0, 32'h44, 32'h0, 2, 1'b1, 32'h1111_CC11);

      // RD_LAT=5, WR_LAT=2 instance: long read, write, re-read
      req(1, 4'hF, 32'h40, 32'h1234_5678, 2, 1'b0, 32'h0);
      req(1, 4'h0, 32'h40, 32'h0, 5, 1'b1, 32'h1234_5678);
      req(1, 4'hF, 32'h40, 32'hDEAD_BEEF, 2, 1'b0, 32'h0);
      req(1, 4'h0, 32'h40, 32'h0, 5, 1'b1, 32'hDEAD_BEEF);

      // Legacy-write instance: three back-to-back writes, no data_ok
      n_en = 0; n_ok = 0;
      for (int i = 0; i < 3; i++) begin
         en_s[2] = 1'b1; wen_s[2] = 4'hF; addr_s[2] = 32'h40 + 32'(4 * i);
         wdata_s[2] = (i == 0) ? 32'hCAFE_F00D : ((i == 1) ? 32'h0102_0304 : 32'h0BAD_C0DE);
         @(negedge clk);
         n_en += int'(ram_en_s[2]); n_ok += int'(ok_s[2]);
         @(posedge clk); #1;
      end
      en_s[2] = 1'b0; wen_s[2] = 4'h0;
      repeat (4) begin
         @(negedge clk);
         n_en += int'(ram_en_s[2]); n_ok += int'(ok_s[2]);
      end
      check("legacy_ram_en_cycles", 32'(n_en), 32'd3);
      check("legacy_data_ok_pulses", 32'(n_ok), 32'd0);
      @(posedge clk); #1;
      req(2, 4'h0, 32'h44, 32'h0, 6, 1'b1, 32'h0102_0304);

      // Reset three cycles into a RD_LAT=6 read: that read must never complete
      en_s[2] = 1'b1; wen_s[2] = 4'h0; addr_s[2] = 32'h48;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      en_s[2] = 1'b0;
      n_ok = 0;
      repeat (10) begin
         @(negedge clk);
         n_ok += int'(ok_s[2]);
      end
      check("abandoned_read_data_ok", 32'(n_ok), 32'd0);
      check("rdata_after_reset", rdata_s[2], 32'h0);
      @(posedge clk); #1;
      req(2, 4'h0, 32'h48, 32'h0, 6, 1'b1, 32'h0BAD_C0DE);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end

endmodule

// File: doc/data_sram_bridge.md
# data_sram_bridge

Parametrised bridge between the CPU data-SRAM port (`en/wen/addr/wdata` in, `rdata/data_ok` out) and a synchronous single-port data RAM with 1-cycle read latency. It replaces the ad-hoc one-cycle `data_ok` flop in the SoC top. It adds:
- configurable read and write latencies, for modelling slower memory;
- optional `data_ok` acknowledgement on writes;
- a held read-data register, so `rdata` stays stable independent of the RAM output.

It sits between `mycpu_top` and `data_ram` inside the SoC top.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; multiple of 8.
- `RD_LAT`, 2, cycles from request-accept cycle to read `data_ok` cycle; legal range 2..15.
- `WR_LAT`, 1, cycles from request-accept cycle to write `data_ok` cycle; legal range 1..15.
- `WR_ACK`, 1, 1 = writes produce `data_ok`; 0 = legacy mode: writes complete in the accept cycle with no `data_ok`.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_en` in 1: request valid; CPU holds the request until `data_ok`.
- `cpu_wen` in DATA_W/8: byte write enables; any bit set = write, else read.
- `cpu_addr` in ADDR_W: request address.
- `cpu_wdata` in DATA_W: write data.
- `cpu_rdata` out DATA_W: held read data.
- `cpu_data_ok` out 1: one-cycle completion pulse.
- `ram_en` out 1: RAM enable.
- `ram_wen` out DATA_W/8: RAM byte write enables.
- `ram_addr` out ADDR_W: RAM address.
- `ram_wdata` out DATA_W: RAM write data.
- `ram_rdata` in DATA_W: RAM read data, valid the cycle after `ram_en`.

## Operation
- FSM states: IDLE, WAIT, DONE.
- **IDLE**, `cpu_en`=1 (accept cycle t):
  - `ram_en`=1; `ram_wen/addr/wdata` pass through combinationally from the CPU side.
  - Latency counter loads `RD_LAT-1` (read) or `WR_LAT-1` (write); `is_read` is latched.
  - Next state: WAIT if counter load > 0, else DONE.
- **Legacy write** (`WR_ACK`=0, write accepted in IDLE): the RAM write is issued and the FSM stays in IDLE; `data_ok` is never pulsed for writes.
- **WAIT**:
  - `ram_en`=0 and `ram_wen`=0; the RAM output therefore holds.
  - Counter decrements each cycle. Counter = 1 → next state DONE.
  - `cpu_en` and all CPU inputs are ignored.
- **DONE**: `cpu_data_ok`=1 (registered, asserted for exactly this cycle); `ram_en`=0; next state IDLE unconditionally. A request present during DONE is not accepted.
- **Read data capture**: on the edge ending cycle t+1 of a read, `cpu_rdata` ← `ram_rdata`. `cpu_rdata` holds until the next read capture; writes do not modify it.
- **Throughput**: one read per `RD_LAT`+1 cycles. With `WR_ACK`=1, one write per `WR_LAT`+1 cycles; with `WR_ACK`=0, one write per cycle.

## Timing
- **Reset** (sampled at a rising edge with `reset`=1):
  - state → IDLE, counter → 0, `cpu_data_ok` → 0, `cpu_rdata` → 0.
  - `ram_en` and `ram_wen` are forced to 0 combinationally while `reset`=1.
- **Reset mid-transaction**: the transaction is abandoned and no `data_ok` is issued. A RAM write already issued in the accept cycle is not undone. The CPU must re-issue after reset.
- **Read**: accept at cycle t; `cpu_rdata` valid from t+2; `cpu_data_ok` high in cycle t+`RD_LAT`. With `RD_LAT`=2 this is t+2, which matches the old flop behaviour.
- **Write**: `ram_en`/`ram_wen` high in cycle t only; `cpu_data_ok` high in cycle t+`WR_LAT` (`WR_ACK`=1).
- **Counter**: width 4 bits, unsigned. A load of 0 skips WAIT; the counter never wraps.
- **Change of request during WAIT/DONE**: no effect; the latched operation type decides the latency.

## Structure
- Package `sram_bridge_pkg`:
  - state enum `bridge_state_t` (IDLE/WAIT/DONE);
  - `LAT_W`=4;
  - functions checking the legal ranges of `RD_LAT`/`WR_LAT`, used in elaboration-time assertions.
- One sub-module: `lat_counter`, a loadable 4-bit down-counter with a `done` flag (count == 1 or load == 0).
- Everything else (FSM, rdata register, RAM-side muxing) is in `data_sram_bridge`.

## Test plan
- **Reset values**: hold `reset`=1 for 3 cycles with `cpu_en`=1 → `ram_en`=0, `cpu_data_ok`=0, `cpu_rdata`=0 throughout.
- **Read, default latency**: `RD_LAT`=2; RAM preloaded with word 0x1234_5678 at 0x40; read 0x40 accepted at t → `ram_en` high only at t, `cpu_rdata`=0x1234_5678 from t+2, `data_ok` pulses at t+2 only, next accept no earlier than t+3.
- **Read, long latency, with write in between**: `RD_LAT`=5; read accepted at t, then a write to 0x40 with data 0xDEAD_BEEF and `wen`=4'hF → `data_ok` at t+5 with the old value; write `data_ok` follows `WR_LAT` cycles after its accept; a re-read of 0x40 returns 0xDEAD_BEEF.
- **Byte-enable write**: `wen`=4'b0010 with wdata 0xAABB_CCDD over word 0x1111_1111 → read-back 0x1111_CC11.
- **Legacy writes**: `WR_ACK`=0; three back-to-back writes → three consecutive `ram_en` cycles, `data_ok` never asserted.
- **Reset mid-WAIT**: `RD_LAT`=6; assert `reset` at accept cycle t+3 → no `data_ok` ever for that read; a fresh read after reset completes normally at accept+6.
